// File: rtl/mips_pkg.sv
// Shared definitions for the execute stage: ALU op encodings, FSM states,
// the control/data bundle captured when a multiply starts, and the
// combinational ALU and branch helpers.
package mips_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_MUL = 3'b011,
    ALU_NOR = 3'b100,
    ALU_XOR = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } ex_state_e;

  // Everything except the product that the EX/MEM bundle needs once a
  // multiply finishes; captured on the cycle the multiply is accepted.
  typedef struct packed {
    logic            we;
    logic [1:0]      mem;
    logic [XLEN-1:0] store_data;
    logic [4:0]      dest;
    logic [XLEN-1:0] target;
  } ex_hold_t;

  // Single-cycle ALU. MUL is produced by the iterative multiplier, so it
  // yields zero here and is never selected for the output on its own.
  function automatic logic [XLEN-1:0] alu_eval(input alu_op_e op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_NOR: r = ~(a | b);
      ALU_XOR: r = a ^ b;
      ALU_MUL: r = '0;
    endcase
    return r;
  endfunction

  // Word offset scaled to bytes and added to PC+4; carry out is dropped.
  function automatic logic [XLEN-1:0] branch_calc(input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] offset);
    return pc + {offset[XLEN-3:0], 2'b00};
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX input bundle, upstream stall, and EX/MEM output bundle of the
// execute stage. The stage itself uses the slave view; whatever feeds it
// (decode stage or a bench) uses the master view.
interface ex_stage_if;

  // ID/EX bundle
  logic        in_valid;
  logic [31:0] PC_pass;
  logic        we_control;
  logic [1:0]  mem_control;
  logic [2:0]  exe_control_alu;
  logic        alu_src;
  logic        reg_dst;
  logic [31:0] reg_1;
  logic [31:0] reg_2;
  logic [31:0] sign_ext;
  logic [4:0]  rt;
  logic [4:0]  rd;

  // back-pressure towards decode
  logic        stall;

  // EX/MEM bundle
  logic        out_valid;
  logic        we_out;
  logic [1:0]  mem_out;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic [31:0] branch_target;
  logic        zero;

  modport master (
    output in_valid, PC_pass, we_control, mem_control, exe_control_alu,
           alu_src, reg_dst, reg_1, reg_2, sign_ext, rt, rd,
    input  stall,
    input  out_valid, we_out, mem_out, alu_result, store_data, dest_reg,
           branch_target, zero
  );

  modport slave (
    input  in_valid, PC_pass, we_control, mem_control, exe_control_alu,
           alu_src, reg_dst, reg_1, reg_2, sign_ext, rt, rd,
    output stall,
    output out_valid, we_out, mem_out, alu_result, store_data, dest_reg,
           branch_target, zero
  );

endinterface

// File: rtl/ex_stage_seq_mul.sv
// Iterative shift-add multiplier: one partial-product step per cycle,
// low XLEN bits of the unsigned product. 'start' loads the operands;
// 'done' is high during the cycle whose edge completes the final step,
// with 'product' already showing the finished value in that cycle.
module seq_mul
  import mips_pkg::*;
#(
  parameter int ITERATIONS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(ITERATIONS + 1);

  logic [XLEN-1:0] mcand_reg;
  logic [XLEN-1:0] mplier_reg;
  logic [XLEN-1:0] acc_reg;
  logic [XLEN-1:0] acc_next;
  logic [CW-1:0]   cnt_reg;
  logic            busy_reg;
  logic            last_iter;

  // Add the shifted multiplicand when the current multiplier bit is set.
  assign acc_next  = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign last_iter = busy_reg && (cnt_reg == CW'(ITERATIONS - 1));
  assign done      = last_iter;
  assign product   = acc_next;

  // Operand load on start, then one shift-add step per busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= a;
      mplier_reg <= b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      if (last_iter) begin
        cnt_reg  <= '0;
        busy_reg <= 1'b0;
      end else begin
        cnt_reg  <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS-style execute stage. Single-cycle ALU ops pass straight into the
// EX/MEM register; MUL hands off to the iterative multiplier, stalls
// decode until the product is ready and emits bubbles meanwhile.
module ex_stage
  import mips_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  ex_stage_if.slave bus
);

  ex_state_e       state_reg;
  ex_state_e       state_next;

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_value;
  logic [XLEN-1:0] branch_value;
  logic [4:0]      dest_value;
  logic            is_mul;

  logic            stall_comb;
  logic            mul_start;
  logic            load_direct;
  logic            load_mul;

  logic            mul_done;
  logic [XLEN-1:0] mul_product;
  ex_hold_t        hold_reg;

  logic            valid_reg;
  logic            we_reg;
  logic [1:0]      mem_reg;
  logic [XLEN-1:0] result_reg;
  logic [XLEN-1:0] store_reg;
  logic [4:0]      dest_sel_reg;
  logic [XLEN-1:0] target_reg;
  logic            zero_reg;

  // Operand select and the purely combinational parts of the datapath.
  assign op_b         = bus.alu_src ? bus.sign_ext : bus.reg_2;
  assign alu_value    = alu_eval(alu_op_e'(bus.exe_control_alu), bus.reg_1, op_b);
  assign branch_value = branch_calc(bus.PC_pass, bus.sign_ext);
  assign dest_value   = bus.reg_dst ? bus.rd : bus.rt;
  assign is_mul       = (bus.exe_control_alu == ALU_MUL);

  seq_mul #(
    .ITERATIONS (MUL_CYCLES)
  ) u_seq_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.reg_1),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: leave IDLE only for a valid MUL, return when the
  // multiplier finishes its last step.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (bus.in_valid && is_mul) state_next = ST_MUL_BUSY;
      ST_MUL_BUSY: if (mul_done)               state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: stall covers the accepting IDLE cycle plus every busy
  // cycle, so decode keeps the MUL bundle steady until the product lands.
  always_comb begin
    stall_comb  = 1'b0;
    mul_start   = 1'b0;
    load_direct = 1'b0;
    load_mul    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.in_valid && is_mul) begin
          stall_comb = 1'b1;
          mul_start  = 1'b1;
        end else if (bus.in_valid) begin
          load_direct = 1'b1;
        end
      end
      ST_MUL_BUSY: begin
        stall_comb = 1'b1;
        load_mul   = mul_done;
      end
      default: ;
    endcase
  end

  // Capture the non-product half of the MUL result so later input
  // changes cannot leak into it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= '0;
    end else if (mul_start) begin
      hold_reg <= '{we:         bus.we_control,
                    mem:        bus.mem_control,
                    store_data: bus.reg_2,
                    dest:       dest_value,
                    target:     branch_value};
    end
  end

  // EX/MEM register: direct ALU result, finished product, or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      we_reg       <= 1'b0;
      mem_reg      <= 2'b00;
      result_reg   <= '0;
      store_reg    <= '0;
      dest_sel_reg <= '0;
      target_reg   <= '0;
      zero_reg     <= 1'b0;
    end else if (load_direct) begin
      valid_reg    <= 1'b1;
      we_reg       <= bus.we_control;
      mem_reg      <= bus.mem_control;
      result_reg   <= alu_value;
      store_reg    <= bus.reg_2;
      dest_sel_reg <= dest_value;
      target_reg   <= branch_value;
      zero_reg     <= (alu_value == '0);
    end else if (load_mul) begin
      valid_reg    <= 1'b1;
      we_reg       <= hold_reg.we;
      mem_reg      <= hold_reg.mem;
      result_reg   <= mul_product;
      store_reg    <= hold_reg.store_data;
      dest_sel_reg <= hold_reg.dest;
      target_reg   <= hold_reg.target;
      zero_reg     <= (mul_product == '0);
    end else begin
      valid_reg    <= 1'b0;
      we_reg       <= 1'b0;
      mem_reg      <= 2'b00;
    end
  end

  assign bus.stall         = stall_comb;
  assign bus.out_valid     = valid_reg;
  assign bus.we_out        = we_reg;
  assign bus.mem_out       = mem_reg;
  assign bus.alu_result    = result_reg;
  assign bus.store_data    = store_reg;
  assign bus.dest_reg      = dest_sel_reg;
  assign bus.branch_target = target_reg;
  assign bus.zero          = zero_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: a cycle-indexed expectation table filled from plain
// arithmetic when each instruction is presented, a per-cycle compare
// process, and literal checks pinning the directed cases.
module tb_ex_stage;

  localparam int MC   = 32;
  localparam int NCYC = 600;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] se;
    logic [31:0] pc;
    logic        asrc;
    logic        rdst;
    logic        we;
    logic [1:0]  mem;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ex_stage_if bus();

  ex_stage #(.MUL_CYCLES(MC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit checking = 1'b0;

  logic        exp_valid [NCYC];
  logic        exp_stall [NCYC];
  logic        exp_we    [NCYC];
  logic [1:0]  exp_mem   [NCYC];
  logic [31:0] exp_res   [NCYC];
  logic [31:0] exp_sd    [NCYC];
  logic [31:0] exp_bt    [NCYC];
  logic [4:0]  exp_dst   [NCYC];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b100:  return ~(a | b);
      3'b101:  return a ^ b;
      default: return a * b;
    endcase
  endfunction

  function automatic instr_t mk(input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] se, input logic [31:0] pc, input logic asrc,
                                input logic rdst, input logic we, input logic [1:0] mem,
                                input logic [4:0] rt, input logic [4:0] rd);
    instr_t x;
    x.op = op; x.r1 = r1; x.r2 = r2; x.se = se; x.pc = pc; x.asrc = asrc;
    x.rdst = rdst; x.we = we; x.mem = mem; x.rt = rt; x.rd = rd;
    return x;
  endfunction

  // Drive one instruction (called at or just after a falling edge), record
  // what must come out and when, then hold it while the stage stalls.
  task automatic issue(input instr_t ins, output int stall_seen);
    int k;
    int t;
    int lat;
    logic [31:0] b;
    logic [31:0] res;
    bus.in_valid        = 1'b1;
    bus.exe_control_alu = ins.op;
    bus.reg_1           = ins.r1;
    bus.reg_2           = ins.r2;
    bus.sign_ext        = ins.se;
    bus.PC_pass         = ins.pc;
    bus.alu_src         = ins.asrc;
    bus.reg_dst         = ins.rdst;
    bus.we_control      = ins.we;
    bus.mem_control     = ins.mem;
    bus.rt              = ins.rt;
    bus.rd              = ins.rd;
    k   = cyc;
    b   = ins.asrc ? ins.se : ins.r2;
    res = model_alu(ins.op, ins.r1, b);
    lat = (ins.op == 3'b011) ? MC + 1 : 1;
    for (int i = 0; i < lat; i++) exp_stall[k + i] = (ins.op == 3'b011);
    t = k + lat;
    exp_valid[t] = 1'b1;
    exp_we[t]    = ins.we;
    exp_mem[t]   = ins.mem;
    exp_res[t]   = res;
    exp_sd[t]    = ins.r2;
    exp_dst[t]   = ins.rdst ? ins.rd : ins.rt;
    exp_bt[t]    = ins.pc + ins.se * 32'd4;
    $display("cycle %0d: op=%b a=%h b=%h -> result %h due in cycle %0d", k, ins.op, ins.r1, b, res, t);
    stall_seen = 0;
    for (int i = 0; i < lat; i++) begin
      #1;
      if (bus.stall === 1'b1) stall_seen++;
      @(negedge clk);
    end
  endtask

  // Idle cycles with a MUL opcode and junk control on the bus: still bubbles.
  task automatic bubble(input int n);
    bus.in_valid        = 1'b0;
    bus.exe_control_alu = 3'b011;
    bus.we_control      = 1'b1;
    bus.mem_control     = 2'b11;
    $display("cycle %0d: %0d bubble cycle(s)", cyc, n);
    repeat (n) @(negedge clk);
  endtask

  // Compare DUT against the expectation table every cycle after reset.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (checking && cyc < NCYC) begin
        chk("stall", bus.stall, exp_stall[cyc]);
        chk("out_valid", bus.out_valid, exp_valid[cyc]);
        if (exp_valid[cyc] === 1'b1) begin
          chk("we_out", bus.we_out, exp_we[cyc]);
          chk("mem_out", bus.mem_out, exp_mem[cyc]);
          chk("alu_result", bus.alu_result, exp_res[cyc]);
          chk("store_data", bus.store_data, exp_sd[cyc]);
          chk("dest_reg", bus.dest_reg, exp_dst[cyc]);
          chk("branch_target", bus.branch_target, exp_bt[cyc]);
          chk("zero", bus.zero, (exp_res[cyc] == 32'd0));
        end else begin
          chk("bubble_we_out", bus.we_out, 1'b0);
          chk("bubble_mem_out", bus.mem_out, 2'b00);
        end
      end
    end
  end

  instr_t alu_vec [10];
  int     ns;
  int     nvalid;

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      exp_valid[i] = 1'b0; exp_stall[i] = 1'b0; exp_we[i] = 1'b0; exp_mem[i] = 2'b00;
      exp_res[i] = '0; exp_sd[i] = '0; exp_bt[i] = '0; exp_dst[i] = '0;
    end
    bus.in_valid = 1'b0; bus.exe_control_alu = 3'b000; bus.reg_1 = '0; bus.reg_2 = '0;
    bus.sign_ext = '0; bus.PC_pass = '0; bus.alu_src = 1'b0; bus.reg_dst = 1'b0;
    bus.we_control = 1'b0; bus.mem_control = 2'b00; bus.rt = '0; bus.rd = '0;

    // power-on reset
    #1 rst_n = 1'b0;
    #2;
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_alu_result", bus.alu_result, 32'd0);
    chk("reset_stall", bus.stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    checking = 1'b1;

    // ADD 5+7 into rd=3
    issue(mk(3'b010, 32'd5, 32'd7, 32'h10, 32'h40, 1'b0, 1'b1, 1'b1, 2'b00, 5'd9, 5'd3), ns);
    #1;
    chk("add_result", bus.alu_result, 32'd12);
    chk("add_dest", bus.dest_reg, 5'd3);
    chk("add_zero", bus.zero, 1'b0);
    chk("add_valid", bus.out_valid, 1'b1);
    chk("add_stall", bus.stall, 1'b0);

    // SUB with immediate: 9-9
    issue(mk(3'b110, 32'd9, 32'd1, 32'd9, 32'h200, 1'b1, 1'b0, 1'b1, 2'b00, 5'd4, 5'd5), ns);
    #1;
    chk("sub_imm_result", bus.alu_result, 32'd0);
    chk("sub_imm_zero", bus.zero, 1'b1);

    // branch target: 0x100 + (4<<2)
    issue(mk(3'b010, 32'd0, 32'd0, 32'd4, 32'h100, 1'b1, 1'b0, 1'b0, 2'b01, 5'd6, 5'd7), ns);
    #1;
    chk("branch_target", bus.branch_target, 32'h110);

    // SLT signed: -1 < 1
    issue(mk(3'b111, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd2), ns);
    #1;
    chk("slt_signed", bus.alu_result, 32'd1);

    // remaining ops and wrap-around corners, checked by the model
    alu_vec[0] = mk(3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h4, 1'b0, 1'b0, 1'b1, 2'b00, 5'd8, 5'd9);
    alu_vec[1] = mk(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'h8, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd10);
    alu_vec[2] = mk(3'b001, 32'hF000_0001, 32'h0000_1000, 32'd0, 32'hC, 1'b0, 1'b0, 1'b1, 2'b00, 5'd11, 5'd2);
    alu_vec[3] = mk(3'b100, 32'h0000_FFFF, 32'hFFFF_0000, 32'd0, 32'h10, 1'b0, 1'b1, 1'b1, 2'b00, 5'd3, 5'd12);
    alu_vec[4] = mk(3'b101, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 32'h14, 1'b0, 1'b0, 1'b1, 2'b00, 5'd13, 5'd4);
    alu_vec[5] = mk(3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h18, 1'b0, 1'b1, 1'b1, 2'b00, 5'd5, 5'd14);
    alu_vec[6] = mk(3'b110, 32'd0, 32'd1, 32'd0, 32'h1C, 1'b0, 1'b0, 1'b1, 2'b00, 5'd15, 5'd6);
    alu_vec[7] = mk(3'b010, 32'h1000, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h80, 1'b1, 1'b0, 1'b0, 2'b01, 5'd16, 5'd7);
    alu_vec[8] = mk(3'b010, 32'h2000, 32'd0, 32'h8, 32'h84, 1'b1, 1'b1, 1'b1, 2'b10, 5'd17, 5'd18);
    alu_vec[9] = mk(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'h88, 1'b0, 1'b1, 1'b1, 2'b00, 5'd19, 5'd20);
    for (int i = 0; i < 10; i++) issue(alu_vec[i], ns);

    bubble(3);

    // MUL 0x10001 * 0x10001, then an ADD waiting behind it
    issue(mk(3'b011, 32'h0001_0001, 32'h0001_0001, 32'd3, 32'h300, 1'b0, 1'b1, 1'b1, 2'b00, 5'd21, 5'd22), ns);
    #1;
    chk("mul_stall_cycles", ns, MC + 1);
    chk("mul_result", bus.alu_result, 32'h0002_0001);
    chk("mul_valid", bus.out_valid, 1'b1);
    issue(mk(3'b010, 32'd100, 32'd23, 32'd0, 32'h304, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd23), ns);
    #1;
    chk("b2b_add_result", bus.alu_result, 32'd123);
    chk("b2b_add_valid", bus.out_valid, 1'b1);

    // more multiplies: wraparound, immediate operand, zero product
    issue(mk(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h400, 1'b0, 1'b0, 1'b1, 2'b00, 5'd24, 5'd25), ns);
    #1;
    chk("mul_wrap", bus.alu_result, 32'd1);
    issue(mk(3'b011, 32'h1234_5678, 32'd0, 32'h9ABC_DEF0, 32'h404, 1'b1, 1'b1, 1'b0, 2'b01, 5'd26, 5'd27), ns);
    issue(mk(3'b011, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'h408, 1'b0, 1'b0, 1'b1, 2'b00, 5'd28, 5'd29), ns);
    #1;
    chk("mul_zero_flag", bus.zero, 1'b1);
    bubble(2);

    // reset in the middle of a multiply (iteration 10)
    issue_abort();

    // recovery
    issue(mk(3'b101, 32'h0000_00FF, 32'h0000_0F0F, 32'd1, 32'h500, 1'b0, 1'b1, 1'b1, 2'b00, 5'd30, 5'd31), ns);
    #1;
    chk("recover_xor", bus.alu_result, 32'h0000_0FF0);
    bubble(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Start a MUL, pulse reset during its tenth busy cycle, and confirm
  // nothing from it ever reaches the output.
  task automatic issue_abort();
    bus.in_valid        = 1'b1;
    bus.exe_control_alu = 3'b011;
    bus.reg_1           = 32'd7;
    bus.reg_2           = 32'd9;
    bus.alu_src         = 1'b0;
    bus.we_control      = 1'b1;
    bus.mem_control     = 2'b00;
    for (int i = 0; i <= MC; i++) exp_stall[cyc + i] = 1'b1;
    $display("cycle %0d: MUL 7*9 to be aborted by reset", cyc);
    repeat (10) @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    for (int i = cyc; i < NCYC; i++) begin
      exp_valid[i] = 1'b0;
      exp_stall[i] = 1'b0;
    end
    #1;
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_we_out", bus.we_out, 1'b0);
    chk("abort_mem_out", bus.mem_out, 2'b00);
    chk("abort_alu_result", bus.alu_result, 32'd0);
    chk("abort_store_data", bus.store_data, 32'd0);
    chk("abort_dest_reg", bus.dest_reg, 5'd0);
    chk("abort_branch_target", bus.branch_target, 32'd0);
    chk("abort_zero", bus.zero, 1'b0);
    chk("abort_stall", bus.stall, 1'b0);
    #2 rst_n = 1'b1;
    nvalid = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.out_valid !== 1'b0) nvalid++;
    end
    chk("abort_no_valid", nvalid, 0);
  endtask

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 32, meaning number of shift-add iterations for the multi-cycle multiply.
REQ-002 SHALL have port clk, input, 1, single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, ID/EX bundle holds a real instruction (0 = bubble).
REQ-005 SHALL have ports PC_pass (input, 32, PC+4), we_control (input, 1, register write), mem_control (input, 2, {mem_read, mem_write}).
REQ-006 SHALL have ports exe_control_alu (input, 3, ALU op), alu_src (input, 1, B = immediate), reg_dst (input, 1, destination = rd).
REQ-007 SHALL have ports reg_1, reg_2, sign_ext (input, 32 each) and rt, rd (input, 5 each): operands and register specifiers.
REQ-008 SHALL have port stall, output, 1, upstream holds the ID/EX bundle stable while high.
REQ-009 SHALL have registered outputs out_valid (1), we_out (1), mem_out (2), alu_result (32), store_data (32), dest_reg (5), branch_target (32) and zero (1), forming the EX/MEM bundle.

Function
REQ-010 SHALL select operand A = reg_1 and operand B = alu_src ? sign_ext : reg_2.
REQ-011 SHALL decode exe_control_alu as 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed, result 1 or 0), 100 NOR, 101 XOR and 011 MUL.
REQ-012 SHALL perform ADD and SUB in 32-bit two's complement, discarding the carry with no overflow trap.
REQ-013 SHALL return MUL as the low 32 bits of the unsigned product A*B.
REQ-014 SHALL compute branch_target = PC_pass + (sign_ext << 2), truncated to 32 bits.
REQ-015 SHALL set dest_reg = reg_dst ? rd : rt, store_data = reg_2 and zero = (alu_result == 0).
REQ-016 SHALL implement an FSM with states IDLE and MUL_BUSY.
REQ-017 In IDLE with in_valid=1 and a non-MUL op, SHALL load all outputs at the next edge with out_valid=1 (1-cycle latency); stall stays 0.
REQ-018 In IDLE with in_valid=0, SHALL load out_valid=0, we_out=0 and mem_out=00 at the next edge; data outputs are don't-care.
REQ-019 In IDLE with in_valid=1 and MUL, SHALL drive stall=1 combinationally, latch the operands and control, and go to MUL_BUSY with the iteration counter at 0.
REQ-020 In MUL_BUSY, SHALL hold stall=1, perform one shift-add iteration per cycle and ignore all inputs.
REQ-021 During MUL_BUSY cycles, SHALL hold out_valid=0, we_out=0 and mem_out=00 (bubbles).
REQ-022 At the edge completing iteration MUL_CYCLES, SHALL load the outputs from the latched values with out_valid=1 and return to IDLE.
REQ-023 SHALL therefore make MUL latency MUL_CYCLES+1 edges, with stall high for MUL_CYCLES+1 consecutive cycles.
REQ-024 SHALL accept a new instruction in the IDLE cycle immediately after a MUL returns, with no dead cycle.
REQ-025 SHALL NOT assert stall for bubbles or non-MUL ops.

Reset
REQ-026 On rst_n=0, SHALL immediately force state IDLE, counter 0 and every registered output to 0; stall SHALL become 0 unless IDLE accepts a new MUL.
REQ-027 Reset asserted during MUL_BUSY SHALL abort the multiply and produce no out_valid.

Structure
REQ-028 SHALL place the ALU op encodings and FSM state encodings in the shared package mips_pkg.
REQ-029 SHALL contain one sub-module, seq_mul (iterative shift-add multiplier with start/done), instantiated once.

Verification
REQ-030 ADD test: reg_1=5, reg_2=7, op=010, alu_src=0, reg_dst=1, rd=3 -> next cycle alu_result=12, dest_reg=3, zero=0, out_valid=1, stall=0.
REQ-031 SUB and immediate test: reg_1=9, sign_ext=9, alu_src=1, op=110 -> alu_result=0, zero=1; with PC_pass=0x100 and sign_ext=4, branch_target=0x110.
REQ-032 SLT signed test: reg_1=0xFFFFFFFF, reg_2=1, op=111 -> alu_result=1.
REQ-033 MUL test: reg_1=0x10001, reg_2=0x10001, op=011 -> stall high for 33 cycles, out_valid low for 32 cycles, then alu_result=0x00020001 with out_valid=1.
REQ-034 Back-to-back test: a MUL followed by an ADD held by stall -> the ADD result appears exactly one cycle after the MUL result.
REQ-035 Reset mid-MUL test: rst_n pulsed low at iteration 10 -> all outputs 0, stall 0, and no out_valid for the aborted MUL.
